// File: rtl/alu_writeback_pkg.sv
// alu_writeback shared types: writeback FSM states and
// register-pair index bits used when splitting 16-bit results.
package alu_writeback_pkg;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_LO   = 2'd1,
    WB_HI   = 2'd2
  } wb_state_e;

  // Register pairs live at an even/odd index couple
  localparam logic PAIR_LO_BIT = 1'b0;
  localparam logic PAIR_HI_BIT = 1'b1;

endpackage

// File: rtl/alu_writeback.sv
// ALU writeback stage: commits 8-bit or 16-bit pair results to the
// register file and flags to flags_q. Optional macro ALU_WB_FWD_EN.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int FLAGS_WIDTH   = 4,
  parameter int REG_IDX_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_hi,
  input  logic [DATA_WIDTH-1:0]    in_lo,
  input  logic [FLAGS_WIDTH-1:0]   in_flags,
  input  logic [REG_IDX_WIDTH-1:0] in_dest,
  input  logic                     in_is_pair,
  input  logic                     in_wr_reg,
  input  logic                     in_wr_flags,
  output logic                     rf_we,
  output logic [REG_IDX_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]    rf_wdata,
  output logic [FLAGS_WIDTH-1:0]   flags_q,
`ifdef ALU_WB_FWD_EN
  output logic                     fwd_valid,
  output logic [REG_IDX_WIDTH-1:0] fwd_idx,
  output logic [DATA_WIDTH-1:0]    fwd_data,
`endif
  output logic                     busy
);

  wb_state_e                r_state;
  logic [DATA_WIDTH-1:0]    r_hi;
  logic [REG_IDX_WIDTH-1:0] r_dest;
  logic                     r_pair;

  logic                     w_accept;
  logic [REG_IDX_WIDTH-1:0] w_lo_idx;
  logic [REG_IDX_WIDTH-1:0] w_hi_idx;

  // Only a pending pair hi write blocks a new result
  assign in_ready = !rst &&
    (r_state == WB_IDLE ||
     (r_state == WB_LO && !r_pair));

  assign w_accept = in_valid && in_ready;
  assign busy     = (r_state != WB_IDLE);

  assign w_lo_idx = in_is_pair
    ? {in_dest[REG_IDX_WIDTH-1:1], PAIR_LO_BIT}
    : in_dest;
  assign w_hi_idx =
    {r_dest[REG_IDX_WIDTH-1:1], PAIR_HI_BIT};

`ifdef ALU_WB_FWD_EN
  assign fwd_valid = rf_we;
  assign fwd_idx   = rf_waddr;
  assign fwd_data  = rf_wdata;
`endif

  // FSM, holding registers, registered write port and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= WB_IDLE;
      r_hi     <= '0;
      r_dest   <= '0;
      r_pair   <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      flags_q  <= '0;
    end else begin
      rf_we <= 1'b0;
      if (w_accept) begin
        r_hi   <= in_hi;
        r_dest <= w_lo_idx;
        r_pair <= in_is_pair;
        if (in_wr_flags)
          flags_q <= in_flags;
        if (in_wr_reg) begin
          r_state  <= WB_LO;
          rf_we    <= 1'b1;
          rf_waddr <= w_lo_idx;
          rf_wdata <= in_lo;
        end else begin
          r_state <= WB_IDLE;
        end
      end else begin
        case (r_state)
          WB_LO: begin
            if (r_pair) begin
              r_state  <= WB_HI;
              rf_we    <= 1'b1;
              rf_waddr <= w_hi_idx;
              rf_wdata <= r_hi;
            end else begin
              r_state <= WB_IDLE;
            end
          end
          WB_HI:   r_state <= WB_IDLE;
          default: r_state <= WB_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback: random and directed results
// checked against a cycle-stamped expected-write queue.
module tb_alu_writeback;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_hi, in_lo;
  logic [3:0] in_flags, in_dest;
  logic       in_is_pair, in_wr_reg, in_wr_flags;
  logic       rf_we;
  logic [3:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [3:0] flags_q;
  logic       busy;
`ifdef ALU_WB_FWD_EN
  logic       fwd_valid;
  logic [3:0] fwd_idx;
  logic [7:0] fwd_data;
`endif

  alu_writeback dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_hi(in_hi), .in_lo(in_lo),
    .in_flags(in_flags), .in_dest(in_dest),
    .in_is_pair(in_is_pair), .in_wr_reg(in_wr_reg),
    .in_wr_flags(in_wr_flags),
    .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .flags_q(flags_q),
`ifdef ALU_WB_FWD_EN
    .fwd_valid(fwd_valid), .fwd_idx(fwd_idx),
    .fwd_data(fwd_data),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    bit [3:0] a;
    bit [7:0] d;
  } wr_t;

  wr_t      q[$];
  int       cyc = 0;
  int       blocked = 0;
  bit [3:0] exp_flags = 0;
  bit       rst_seen = 0;
  bit       mon_en = 0;
  bit       got_acc = 0;
  int       n_pass = 0;
  int       n_total = 0;

  task automatic chk(string nm, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                  nm, cyc, act, exp);
  endtask

  // Reference model: a result either commits flags, schedules
  // one write next cycle, or schedules an even/odd pair of writes
  always @(posedge clk) begin
    bit rdy;
    int base;
    rdy = !rst && blocked == 0;
    cyc++;
    mon_en = 1;
    got_acc = 0;
    if (blocked > 0) blocked--;
    if (rst) begin
      q.delete();
      exp_flags = 0;
      blocked = 0;
      rst_seen = 1;
    end else begin
      rst_seen = 0;
      if (in_valid && rdy) begin
        got_acc = 1;
        if (in_wr_flags) exp_flags = in_flags;
        if (in_wr_reg) begin
          if (in_is_pair) begin
            base = (int'(in_dest) / 2) * 2;
            q.push_back('{cyc, 4'(base), in_lo});
            q.push_back('{cyc + 1, 4'(base + 1), in_hi});
            blocked = 2;
          end else begin
            q.push_back('{cyc, in_dest, in_lo});
          end
        end
      end
    end
  end

  // Monitor: compares DUT outputs mid-cycle against the model
  always @(negedge clk) begin
    bit exp_we;
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missed_write", 0, 1);
        void'(q.pop_front());
      end
      exp_we = q.size() > 0 && q[0].cyc == cyc;
      chk("in_ready", int'(in_ready),
          int'(!rst && blocked == 0));
      chk("rf_we", int'(rf_we), int'(exp_we));
      chk("busy", int'(busy), int'(exp_we));
      chk("flags_q", int'(flags_q), int'(exp_flags));
      if (exp_we) begin
        chk("rf_waddr", int'(rf_waddr), int'(q[0].a));
        chk("rf_wdata", int'(rf_wdata), int'(q[0].d));
`ifdef ALU_WB_FWD_EN
        chk("fwd_valid", int'(fwd_valid), 1);
        chk("fwd_idx", int'(fwd_idx), int'(q[0].a));
        chk("fwd_data", int'(fwd_data), int'(q[0].d));
`endif
        void'(q.pop_front());
      end
      if (rst_seen) begin
        chk("rst_waddr", int'(rf_waddr), 0);
        chk("rst_wdata", int'(rf_wdata), 0);
      end
    end
  end

  task automatic send(bit [7:0] hi, bit [7:0] lo,
                      bit [3:0] fl, bit [3:0] dst,
                      bit pr, bit wr, bit wf);
    bit ok;
    in_valid = 1; in_hi = hi; in_lo = lo;
    in_flags = fl; in_dest = dst; in_is_pair = pr;
    in_wr_reg = wr; in_wr_flags = wf;
    ok = 0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(posedge clk); #1;
      ok = got_acc;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic idle(int n);
    in_valid = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_rst();
    in_valid = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_hi = 0; in_lo = 0;
    in_flags = 0; in_dest = 0; in_is_pair = 0;
    in_wr_reg = 0; in_wr_flags = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    idle(1);
    send(8'h00, 8'h3C, 4'b0010, 4'd5, 0, 1, 1);
    idle(2);
    send(8'hFF, 8'hFE, 4'b1000, 4'd7, 1, 1, 1);
    idle(3);
    send(8'h00, 8'h00, 4'b0001, 4'd0, 0, 0, 1);
    idle(2);
    send(8'h00, 8'h11, 4'b0000, 4'd1, 0, 1, 0);
    send(8'h00, 8'h22, 4'b0000, 4'd2, 0, 1, 0);
    send(8'h00, 8'h33, 4'b0000, 4'd3, 0, 1, 0);
    idle(2);
    send(8'hA5, 8'h5A, 4'b0100, 4'd15, 1, 1, 1);
    idle(3);
    send(8'hAA, 8'hBB, 4'b0110, 4'd2, 1, 1, 1);
    pulse_rst();
    idle(3);
    send(8'h00, 8'hA5, 4'b0000, 4'd9, 0, 1, 0);
    idle(2);
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 49) == 0) pulse_rst();
      else if ($urandom_range(0, 3) == 0) idle(1);
      else send(8'($urandom), 8'($urandom),
                4'($urandom), 4'($urandom),
                1'($urandom), 1'($urandom_range(0, 3) != 0),
                1'($urandom));
    end
    idle(5);
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
